shift_sequencer: RTL and testbench

//   Multi-cycle controller that drives the single-bit shifter datapath
//   (in[15:0], shift[1:0] -> sout[15:0]). It performs a shift of 0..15

---
 rtl/shift_sequencer.sv | 121 ++++++++++++
 tb/tb_shift_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle controller for an external single-bit shifter. The shifter has
// ports in[WIDTH-1:0], shift[1:0] and sout[WIDTH-1:0]. This block performs a
// shift of 0..2**CNT_W-1 positions. It does this by loading the shifter result
// back into an accumulator once per cycle, `amount` times. The shifter itself
// lives outside this block; here we only sequence it.
//
// Ports
//   clk       in   1       rising-edge clock
//   reset_n   in   1       asynchronous reset, active-low
//   start     in   1       request; sampled only while idle
//   op        in   2       00 none, 01 LSL, 10 LSR, 11 ASR (shifter encoding)
//   amount    in   CNT_W   number of 1-bit shift steps
//   din       in   WIDTH   operand; captured when start is accepted
//   busy      out  1       high in every state except IDLE
//   done      out  1       one-cycle pulse when dout holds a fresh result
//   dout      out  WIDTH   result; holds until the next completion
//   sh_in     out  WIDTH   drives shifter .in (the accumulator)
//   sh_shift  out  2       drives shifter .shift
//   sh_sout   in   WIDTH   shifter .sout (combinational return path)
// -----------------------------------------------------------------------------
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] sh_in,
  output logic [1:0]       sh_shift,
  input  logic [WIDTH-1:0] sh_sout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0]       OP_NONE = 2'b00;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_r;

  // The accumulator always feeds the shifter. The shift code is only
  // presented while stepping, so the shifter passes data through otherwise.
  assign sh_in    = acc;
  assign sh_shift = (state == SHIFT) ? op_r : OP_NONE;

  // NOTE: every register in this process uses non-blocking assignment.
  // Each branch can then read the pre-edge value of state/cnt/acc,
  // whatever order the statements appear in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      op_r  <= OP_NONE;
      dout  <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      // done is a single-cycle pulse. It is only set on the edge that
      // enters DONE.
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            acc  <= din;
            cnt  <= amount;
            op_r <= op;
            busy <= 1'b1;
            // Nothing to shift: the operand is already the result.
            if (amount == '0 || op == OP_NONE) begin
              state <= DONE;
              dout  <= din;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end

        SHIFT: begin
          acc <= sh_sout;
          cnt <= cnt - CNT_ONE;
          // On the last step, sh_sout is the final accumulator value.
          // Capture it directly so dout is valid in the same cycle as done.
          if (cnt == CNT_ONE) begin
            state <= DONE;
            dout  <= sh_sout;
            done  <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [CNT_W-1:0] amount = '0;
  logic [WIDTH-1:0] din = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] sh_in;
  logic [1:0]       sh_shift;
  logic [WIDTH-1:0] sh_sout;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .amount   (amount),
    .din      (din),
    .busy     (busy),
    .done     (done),
    .dout     (dout),
    .sh_in    (sh_in),
    .sh_shift (sh_shift),
    .sh_sout  (sh_sout)
  );

  always #5 clk = ~clk;

  // External single-bit shifter that the sequencer drives.
  always_comb begin
    sh_sout = sh_in;
    case (sh_shift)
      2'b01:   sh_sout = {sh_in[WIDTH-2:0], 1'b0};
      2'b10:   sh_sout = {1'b0, sh_in[WIDTH-1:1]};
      2'b11:   sh_sout = {sh_in[WIDTH-1], sh_in[WIDTH-1:1]};
      default: sh_sout = sh_in;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               done_cyc;
    int               shifts;
    logic [1:0]       op;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   shift_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Whole-operation reference: a shift by `a` positions in one step.
  function automatic logic [WIDTH-1:0] ref_result(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] o,
                                                  input logic [CNT_W-1:0] a);
    case (o)
      2'b01:   return d << a;
      2'b10:   return d >> a;
      2'b11:   return WIDTH'($signed(d) >>> a);
      default: return d;
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever the DUT reports completion.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (sh_shift != 2'b00) begin
        shift_seen++;
        if (sb.size() > 0) check("sh_shift_code", sh_shift, sb[0].op);
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("done_without_op", done, 1'b0);
        end else begin
          e = sb.pop_front();
          check("dout", dout, e.data);
          check("latency", cyc, e.done_cyc);
          check("shift_steps", shift_seen, e.shifts);
        end
        shift_seen = 0;
      end
    end
  end

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  // Issues one request and pushes its expected response into the scoreboard.
  // It returns at the negedge right after the accept edge.
  task automatic issue(input logic [WIDTH-1:0] d, input logic [1:0] o,
                       input logic [CNT_W-1:0] a);
    int n;
    wait_idle();
    n = (o == 2'b00) ? 0 : int'(a);
    din    = d;
    op     = o;
    amount = a;
    start  = 1'b1;
    sb.push_back('{data: ref_result(d, o, a), done_cyc: cyc + 1 + n, shifts: n, op: o});
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    // Reset state.
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dout", dout, 16'h0000);
    check("rst_sh_in", sh_in, 16'h0000);
    check("rst_sh_shift", sh_shift, 2'b00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed operations.
    issue(16'hF0CF, 2'b01, 4'd3);
    check("lsl_model", ref_result(16'hF0CF, 2'b01, 4'd3), 16'h8678);
    issue(16'hF0CF, 2'b10, 4'd4);
    issue(16'hF0CF, 2'b11, 4'd4);
    issue(16'h8000, 2'b11, 4'd15);
    issue(16'hFFFF, 2'b01, 4'd15);
    issue(16'h70CF, 2'b01, 4'd0);
    issue(16'h70CF, 2'b00, 4'd5);

    // Busy lockout: start stays high with new operands during an operation.
    issue(16'hF0CF, 2'b10, 4'd5);
    start  = 1'b1;
    din    = 16'hFFFF;
    op     = 2'b11;
    amount = 4'd1;
    repeat (3) @(negedge clk);
    check("busy_during_op", busy, 1'b1);
    start = 1'b0;
    issue(16'h1234, 2'b01, 4'd4);

    // Reset in the middle of a long shift.
    issue(16'hBEEF, 2'b01, 4'd10);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_dout", dout, 16'h0000);
    check("midrst_sh_shift", sh_shift, 2'b00);
    sb.delete();
    shift_seen = 0;
    @(negedge clk);
    reset_n = 1'b1;
    issue(16'hF0CF, 2'b01, 4'd3);

    // Random operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      issue(16'($urandom), 2'($urandom), 4'($urandom));
    end

    wait_idle();
    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
